// File: rtl/wb_stage.sv
// MEM/WB pipeline stage: selects and extends the memory-stage result, registers it,
// drives the register file write port with a same-cycle bypass, and counts retired instructions.
module wb_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_write,
  input  logic             in_mem_to_reg,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_mem_data,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_write_data,
  output logic             wb_reg_write,
  output logic             fwd1_hit,
  output logic             fwd2_hit,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] instret
);

  logic             r_v;
  logic [4:0]       r_rd;
  logic             r_rw;
  logic [XLEN-1:0]  r_data;
  logic [CNT_W-1:0] r_instret;

  logic [XLEN-1:0]  w_load;
  logic [XLEN-1:0]  w_sel;
  logic             w_capture;
  logic             w_we;

  // Extension happens before capture so the stage register holds the final write value.
  always_comb begin
    w_load = in_mem_data;
    case (in_funct3)
      3'b000:  w_load = {{(XLEN-8){in_mem_data[7]}},   in_mem_data[7:0]};
      3'b001:  w_load = {{(XLEN-16){in_mem_data[15]}}, in_mem_data[15:0]};
      3'b010:  w_load = {{(XLEN-32){in_mem_data[31]}}, in_mem_data[31:0]};
      3'b100:  w_load = {{(XLEN-8){1'b0}},  in_mem_data[7:0]};
      3'b101:  w_load = {{(XLEN-16){1'b0}}, in_mem_data[15:0]};
      3'b110:  w_load = {{(XLEN-32){1'b0}}, in_mem_data[31:0]};
      default: w_load = in_mem_data;
    endcase
  end

  assign w_sel     = in_mem_to_reg ? w_load : in_alu_result;
  assign w_capture = !flush && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v       <= 1'b0;
      r_rd      <= '0;
      r_rw      <= 1'b0;
      r_data    <= '0;
      r_instret <= '0;
    end else if (flush) begin
      r_v <= 1'b0;
    end else if (w_capture) begin
      r_v    <= in_valid;
      r_rd   <= in_rd;
      r_rw   <= in_reg_write;
      r_data <= w_sel;
      if (in_valid) r_instret <= r_instret + CNT_W'(1);
    end
  end

  // x0 is never written, which also keeps it out of the bypass compare.
  assign w_we          = r_v && r_rw && (r_rd != 5'd0);
  assign wb_reg_write  = w_we;
  assign wb_rd         = r_rd;
  assign wb_write_data = r_data;
  assign fwd_data      = r_data;
  assign fwd1_hit      = w_we && (rs1 == r_rd);
  assign fwd2_hit      = w_we && (rs2 == r_rd);
  assign instret       = r_instret;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline stage that drives the register file write port: rd, write_data and reg_write.
- Registers the memory-stage result and selects ALU result or load data.
- Sign- or zero-extends loads per funct3.
- Provides a same-cycle bypass so decode-stage reads of a register being written this cycle see the new value.
- Keeps a retired-instruction counter.

Parameters:
- XLEN, 64, datapath width; also the width of alu_result, mem_data and write_data.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold the stage register.
- flush  input  1  invalidate the stage register.
- in_valid  input  1  the memory stage holds a real instruction.
- in_rd  input  5  destination register.
- in_reg_write  input  1  the instruction writes rd.
- in_mem_to_reg  input  1  1 = select load data, 0 = select ALU result.
- in_funct3  input  3  load size and signedness.
- in_alu_result  input  XLEN  ALU result.
- in_mem_data  input  XLEN  raw data memory read word; the byte/half/word is at bits [7:0]/[15:0]/[31:0].
- rs1  input  5  decode-stage source register 1.
- rs2  input  5  decode-stage source register 2.
- wb_rd  output  5  register file destination.
- wb_write_data  output  XLEN  register file write data.
- wb_reg_write  output  1  register file write enable.
- fwd1_hit  output  1  rs1 matches the write in flight.
- fwd2_hit  output  1  rs2 matches the write in flight.
- fwd_data  output  XLEN  bypass value; always equals wb_write_data.
- instret  output  CNT_W  count of retired instructions.

Behaviour:
- Stage state: v, rd, rw, data. The load mux and extension are applied before capture, so data holds the final value.
- Rising-edge priority:
  - reset: v=0, rd=0, rw=0, data=0, instret=0.
  - else flush: v=0; other fields don't-care (hold); instret unchanged.
  - else stall: all state held; instret unchanged.
  - else capture: v=in_valid, rd=in_rd, rw=in_reg_write, data=sel; instret += 1 when in_valid.
- flush wins over stall when both are high.
- Data select:
  - in_mem_to_reg=0: sel = in_alu_result.
  - in_mem_to_reg=1, by in_funct3:
    - 000 LB: sign-extend [7:0].
    - 001 LH: sign-extend [15:0].
    - 010 LW: sign-extend [31:0].
    - 011 LD: full word.
    - 100 LBU: zero-extend [7:0].
    - 101 LHU: zero-extend [15:0].
    - 110 LWU: zero-extend [31:0].
    - 111: treated as LD.
- Outputs, combinational from stage state:
  - wb_reg_write = v & rw & (rd != 0).
  - wb_rd = rd.
  - wb_write_data = data.
- Latency: one cycle from memory-stage inputs to the register file write port.
- While stalled, the same write is re-presented each cycle. This is idempotent at the register file and is not recounted in instret.
- Bypass, combinational:
  - fwd1_hit = wb_reg_write & (rs1 == wb_rd); fwd2_hit is the same with rs2.
  - x0 never hits, since wb_reg_write is 0 when rd=0.
  - fwd_data = wb_write_data.
- instret:
  - Increments by exactly 1 per captured valid instruction, whether or not it writes rd (stores and branches count).
  - Wraps modulo 2^CNT_W without saturation or flag.
- Reset mid-stall or mid-flush: reset dominates; outputs are inactive from the cycle after the reset edge.
- Bubbles (in_valid=0) propagate as v=0 with no write and no count.

Test Plan:
- Reset then ALU op: in_valid=1, in_rd=5, in_reg_write=1, in_mem_to_reg=0, in_alu_result=0x1234 -> next cycle wb_reg_write=1, wb_rd=5, wb_write_data=0x1234, instret=1.
- Load extension: in_mem_data=0x00000000_8000_80F0, in_mem_to_reg=1, captured once per funct3 ->
  - LB: 0xFFFFFFFFFFFFFFF0
  - LBU: 0xF0
  - LH: 0xFFFFFFFFFFFF80F0
  - LHU: 0x80F0
  - LW: 0xFFFFFFFF800080F0
  - LWU: 0x800080F0
  - LD: unchanged
- rd=0 write: in_rd=0, in_reg_write=1, rs1=0 -> wb_reg_write=0, fwd1_hit=0, instret still increments.
- Bypass: stage holds rd=7, data=0xAB, rw=1; rs1=7, rs2=8 -> fwd1_hit=1, fwd2_hit=0, fwd_data=0xAB.
- Stall/flush: stall=1 for 3 cycles with new inputs -> outputs and instret frozen. Then stall=1 and flush=1 together -> wb_reg_write=0 next cycle.
- Wrap: CNT_W=4, 17 valid captures -> instret=1. Assert reset during a valid write -> the next cycle has all outputs 0.
